// File: rtl/cons.sv
// cons: sink for the 8-bit val/data stream. Contiguous val=1 beats form a
// packet that is measured for length, sum and out-of-range data. Each packet
// produces a one-cycle report and increments a running packet count.
// Runs longer than MAX_LEN are split without dropping any beat.
// Optional feature macro: CONS_GAP_STATS_EN adds an idle-gap counter.
// The counter value is reported on pkt_gap; without the macro, pkt_gap is 0.
module cons #(
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned DATA_MAX = 5,
    parameter int unsigned LEN_W    = 5,
    parameter int unsigned SUM_W    = 12,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             val,
    input  logic [7:0]       data,
    output logic             pkt_valid,
    output logic [LEN_W-1:0] pkt_len,
    output logic [SUM_W-1:0] pkt_sum,
    output logic             pkt_err,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [7:0]       pkt_gap,
    output logic             busy
);

    typedef enum logic {IDLE, ACC} state_t;

    state_t           state;
    logic [LEN_W-1:0] acc_len;
    logic [SUM_W-1:0] acc_sum;
    logic             acc_err;

    logic beat_err_c;
    logic at_max_c;

    // Per-beat range check and accumulator-full detection
    assign beat_err_c = (32'(data) > DATA_MAX);
    assign at_max_c   = (acc_len == LEN_W'(MAX_LEN));

    // Packet FSM: accumulate beats, report on idle or on a MAX_LEN split
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc_len   <= '0;
            acc_sum   <= '0;
            acc_err   <= 1'b0;
            pkt_valid <= 1'b0;
            pkt_len   <= '0;
            pkt_sum   <= '0;
            pkt_err   <= 1'b0;
            pkt_cnt   <= '0;
            busy      <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (val) begin
                        acc_len <= LEN_W'(1);
                        acc_sum <= SUM_W'(data);
                        acc_err <= beat_err_c;
                        state   <= ACC;
                        busy    <= 1'b1;
                    end
                end
                ACC: begin
                    if (!val || at_max_c) begin
                        pkt_valid <= 1'b1;
                        pkt_len   <= acc_len;
                        pkt_sum   <= acc_sum;
                        pkt_err   <= acc_err;
                        pkt_cnt   <= pkt_cnt + CNT_W'(1);
                    end
                    if (!val) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (at_max_c) begin
                        // split: the current beat opens the next packet
                        acc_len <= LEN_W'(1);
                        acc_sum <= SUM_W'(data);
                        acc_err <= beat_err_c;
                    end else begin
                        acc_len <= acc_len + LEN_W'(1);
                        acc_sum <= acc_sum + SUM_W'(data);
                        acc_err <= acc_err | beat_err_c;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CONS_GAP_STATS_EN
    logic [7:0] gap_cnt;
    logic [7:0] gap_cap;

    // Idle-gap counter: saturating count of val=0 cycles, captured per packet
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= '0;
            gap_cap <= '0;
            pkt_gap <= '0;
        end else begin
            if (!val) begin
                if (gap_cnt != 8'hFF) gap_cnt <= gap_cnt + 8'd1;
            end else if (state == IDLE) begin
                gap_cap <= gap_cnt;
                gap_cnt <= '0;
            end
            if (state == ACC && (!val || at_max_c)) pkt_gap <= gap_cap;
            // a packet opened by a split has no preceding gap
            if (state == ACC && val && at_max_c) gap_cap <= '0;
        end
    end
`else
    assign pkt_gap = '0;
`endif

endmodule

// File: tb/tb_cons.sv
// Randomized and directed bench for cons against a queue-based packet model.
module tb_cons;

    localparam int unsigned MAX_LEN  = 16;
    localparam int unsigned DATA_MAX = 5;

    logic        clk;
    logic        rst;
    logic        val;
    logic [7:0]  data;
    logic        pkt_valid;
    logic [4:0]  pkt_len;
    logic [11:0] pkt_sum;
    logic        pkt_err;
    logic [15:0] pkt_cnt;
    logic [7:0]  pkt_gap;
    logic        busy;

    cons dut (
        .clk      (clk),
        .rst      (rst),
        .val      (val),
        .data     (data),
        .pkt_valid(pkt_valid),
        .pkt_len  (pkt_len),
        .pkt_sum  (pkt_sum),
        .pkt_err  (pkt_err),
        .pkt_cnt  (pkt_cnt),
        .pkt_gap  (pkt_gap),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // Reference model state: beats of the open packet and report fields
    int beats[$];
    bit in_pkt;
    int gap;
    int cur_gap;
    int exp_valid, exp_len, exp_sum, exp_err, exp_cnt, exp_gap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit v, input int d);
        int s;
        bit e;
        if (r) begin
            beats.delete();
            in_pkt = 0; gap = 0; cur_gap = 0;
            exp_valid = 0; exp_len = 0; exp_sum = 0; exp_err = 0; exp_cnt = 0; exp_gap = 0;
            return;
        end
        exp_valid = 0;
        if (in_pkt && (!v || beats.size() == MAX_LEN)) begin
            s = 0; e = 0;
            foreach (beats[i]) begin
                s += beats[i];
                if (beats[i] > DATA_MAX) e = 1;
            end
            exp_valid = 1;
            exp_len   = beats.size();
            exp_sum   = s;
            exp_err   = e;
            exp_cnt   = (exp_cnt + 1) % 65536;
            exp_gap   = cur_gap;
            beats.delete();
            if (!v) in_pkt = 0;
            else cur_gap = 0;
        end
        if (v) begin
            if (!in_pkt) begin
                cur_gap = gap;
                gap = 0;
                in_pkt = 1;
            end
            beats.push_back(d);
        end else begin
            gap = (gap < 255) ? gap + 1 : 255;
        end
    endtask

    task automatic step(input bit r, input bit v, input int d);
        int g;
        rst = r; val = v; data = 8'(d);
        @(posedge clk);
        model(r, v, d);
        @(negedge clk);
`ifdef CONS_GAP_STATS_EN
        g = exp_gap;
`else
        g = 0;
`endif
        chk("pkt_valid", 32'(pkt_valid), 32'(exp_valid));
        chk("busy",      32'(busy),      32'(in_pkt));
        chk("pkt_cnt",   32'(pkt_cnt),   32'(exp_cnt));
        chk("pkt_len",   32'(pkt_len),   32'(exp_len));
        chk("pkt_sum",   32'(pkt_sum),   32'(exp_sum));
        chk("pkt_err",   32'(pkt_err),   32'(exp_err));
        chk("pkt_gap",   32'(pkt_gap),   32'(g));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic burst(input int n, input int d);
        for (int i = 0; i < n; i++) step(0, 1, d);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1; val = 1'b0; data = 8'd0;
        model(1, 0, 0);
        @(negedge clk);

        // reset state
        step(1, 0, 0);
        step(1, 1, 9);

        // 1,2,3 -> len 3 sum 6
        step(0, 1, 1); step(0, 1, 2); step(0, 1, 3); idle(2);
        // 4,4 | 5 with one-cycle gap -> two packets
        burst(2, 4); idle(1); step(0, 1, 5); idle(2);
        // 18 beats of 2 -> split at MAX_LEN
        burst(18, 2); idle(2);
        // out-of-range beat confined to its own packet
        step(0, 1, 1); step(0, 1, 7); step(0, 1, 0); idle(1);
        burst(2, 3); idle(1);
        // reset in mid-burst discards the partial packet
        burst(2, 4); step(1, 0, 0); burst(2, 5); idle(2);
        // gap capture and saturation
        burst(1, 1); idle(3); burst(2, 1); idle(300); burst(3, 2); idle(1);
        // back-to-back splits
        burst(40, 255); idle(1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int d;
            bit v;
            d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 255)) : int'($urandom_range(0, 5));
            v = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 199) == 0) step(1, v, d);
            else if ($urandom_range(0, 99) == 0) burst(int'($urandom_range(14, 35)), d);
            else step(0, v, d);
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cons.md
Name: cons

Overview:
- Consumer for the 8-bit val/data stream that the stream producer drives; valid-only, no back-pressure, so the consumer samples every cycle.
- Groups contiguous val=1 beats into packets and measures each packet's length, sum and range errors.
- Emits a one-cycle packet report and keeps a running packet count. Sits at the sink end of the producer's link.

Parameters:
- MAX_LEN, 16: maximum beats per packet; a longer run is split.
- DATA_MAX, 5: largest legal data value; anything above it is an error.
- LEN_W, 5: width of pkt_len; must hold MAX_LEN.
- SUM_W, 12: width of pkt_sum; must be at least 8+clog2(MAX_LEN), so no overflow is possible.
- CNT_W, 16: width of pkt_cnt.

Ports:
- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- val  input  1  data valid from producer
- data  input  8  stream data; sampled only when val=1
- pkt_valid  output  1  one-cycle pulse; report fields valid
- pkt_len  output  LEN_W  beats in reported packet
- pkt_sum  output  SUM_W  unsigned sum of the packet's data
- pkt_err  output  1  at least one beat had data > DATA_MAX
- pkt_cnt  output  CNT_W  total packets reported; wraps
- pkt_gap  output  8  idle cycles before the packet (optional feature only)
- busy  output  1  high while a packet is being accumulated

Behaviour:
- Synchronous reset, active high. When rst=1 at a posedge, all outputs go to 0 and state goes to IDLE.
  - Any partial packet is discarded with no report.
  - rst has priority over val.
- State IDLE:
  - val=1 → load acc_len=1, acc_sum=data, acc_err=(data>DATA_MAX), go to ACC.
  - val=0 → stay in IDLE.
- State ACC, val=1 and acc_len<MAX_LEN → acc_len+1, acc_sum+data, acc_err|=(data>DATA_MAX); stay in ACC.
- State ACC, val=0 → report the packet and go to IDLE.
- State ACC, val=1 and acc_len==MAX_LEN → at the same edge:
  - report the current packet (len=MAX_LEN);
  - restart accumulation with the current beat (len=1, sum=data, err per this beat);
  - stay in ACC. No beat is lost.
- Report, at the edge that samples the closing condition:
  - pkt_valid=1 for exactly one cycle;
  - pkt_len, pkt_sum, pkt_err are loaded from the accumulator;
  - pkt_cnt increments, wrapping to 0 after its maximum.
- Latency: pkt_valid is high in the cycle after the edge that sampled the first val=0 (or the split beat).
- Between reports, pkt_len/pkt_sum/pkt_err/pkt_cnt hold their last values; pkt_valid=0.
- A one-cycle val=0 gap between bursts gives two separate packets. A zero-cycle gap merges the bursts into one packet.
- An out-of-range beat is still added to the sum; its error is reported with its own packet only.
- busy = (state==ACC).

Optional Feature:
- Macro: CONS_GAP_STATS_EN.
- Defined:
  - An 8-bit gap counter counts val=0 cycles and saturates at 255.
  - Counting starts after reset release and after the last beat of the previous packet; the cycle that closes a packet counts as 1.
  - On a packet's first beat (in IDLE), the counter value is captured and then cleared.
  - The captured value goes out on pkt_gap with that packet's report. A packet created by a MAX_LEN split reports pkt_gap=0.
  - Reset clears the counter and pkt_gap.
- Not defined: pkt_gap is tied to 0 and there is no counter logic.

Test Plan:
- Reset, then val=1 with data 1,2,3, then val=0 → one cycle after the first idle edge: pkt_valid=1, pkt_len=3, pkt_sum=6, pkt_err=0, pkt_cnt=1; pkt_valid=0 the next cycle.
- Beats 4,4, one idle cycle, beat 5, idle → two reports: (len 2, sum 8) then (len 1, sum 5); pkt_cnt=2.
- 18 consecutive beats of data 2 (MAX_LEN=16), then idle → report len 16/sum 32 while val is still high, then report len 2/sum 4; busy stays high through the split.
- Beats 1,7,0, idle, beats 3,3, idle → first report len 3, sum 8, err 1; second report len 2, sum 6, err 0.
- rst pulsed for one cycle after 2 beats of a burst → no report, all outputs 0, pkt_cnt=0; the next burst 5,5 reports len 2, sum 10, cnt 1.
- With CONS_GAP_STATS_EN: burst, 3 idle cycles, burst → second report has pkt_gap=3. A 300-cycle gap gives pkt_gap=255. Without the macro, pkt_gap=0 always.
